// File: rtl/alarm_melody_sequencer.sv
// Alarm melody sequencer: walks a note table held in an external synchronous ROM
// and drives period/enable to the tone generator, with stop, snooze and auto-timeout.
module alarm_melody_sequencer #(
    parameter int TICK_DIV     = 100_000,
    parameter int NOTES        = 16,
    parameter int PERIOD_W     = 20,
    parameter int DUR_W        = 10,
    parameter int GAP_TICKS    = 20,
    parameter int REPEATS      = 8,
    parameter int SNOOZE_TICKS = 300_000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     alarm_trig,
    input  logic                     stop,
    input  logic                     snooze,
    output logic [$clog2(NOTES)-1:0] rom_addr,
    input  logic [PERIOD_W-1:0]      rom_period,
    input  logic [DUR_W-1:0]         rom_dur,
    output logic [PERIOD_W-1:0]      tone_period,
    output logic                     tone_en,
    output logic                     busy,
    output logic                     alarm_done
);

    localparam int AW     = $clog2(NOTES);
    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LOOP_W = $clog2(REPEATS + 1);
    localparam int SN_W   = $clog2(SNOOZE_TICKS + 1);
    localparam int GP_W   = $clog2(GAP_TICKS + 2);
    localparam int CNT_A  = (DUR_W > SN_W) ? DUR_W : SN_W;
    localparam int CNT_W  = (CNT_A > GP_W) ? CNT_A : GP_W;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, SNOOZE} state_t;

    state_t              state, state_n;
    logic [AW-1:0]       idx, idx_n;
    logic [LOOP_W-1:0]   loop, loop_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [PRE_W-1:0]    pre, pre_n;
    logic [PERIOD_W-1:0] period_n;
    logic                done_n;
    logic                tick;
    logic                step;
    logic                wrap;

    assign tick     = (pre == PRE_W'(TICK_DIV - 1));
    assign rom_addr = idx;

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        loop_n   = loop;
        cnt_n    = cnt;
        pre_n    = tick ? '0 : pre + PRE_W'(1);
        period_n = tone_period;
        done_n   = 1'b0;
        step     = 1'b0;
        wrap     = 1'b0;

        if (stop) begin
            state_n = IDLE;
        end else if (snooze && (state != IDLE)) begin
            // Re-entry from SNOOZE itself restarts the full snooze interval.
            state_n = SNOOZE;
            cnt_n   = CNT_W'(SNOOZE_TICKS);
            pre_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (alarm_trig) begin
                        state_n = FETCH;
                        idx_n   = '0;
                        loop_n  = '0;
                    end
                end
                FETCH: state_n = LOAD;
                LOAD: begin
                    if (rom_dur == '0) begin
                        wrap = 1'b1;
                    end else begin
                        period_n = rom_period;
                        cnt_n    = CNT_W'(rom_dur);
                        pre_n    = '0;
                        state_n  = PLAY;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        if (cnt <= CNT_W'(1)) begin
                            if (GAP_TICKS == 0) begin
                                step = 1'b1;
                            end else begin
                                state_n = GAP;
                                cnt_n   = CNT_W'(GAP_TICKS);
                                pre_n   = '0;
                            end
                        end else begin
                            cnt_n = cnt - CNT_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (cnt <= CNT_W'(1)) step = 1'b1;
                        else                  cnt_n = cnt - CNT_W'(1);
                    end
                end
                SNOOZE: begin
                    if (tick) begin
                        if (cnt <= CNT_W'(1)) begin
                            state_n = FETCH;
                            idx_n   = '0;
                            loop_n  = '0;
                        end else begin
                            cnt_n = cnt - CNT_W'(1);
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (step) begin
            if (idx == AW'(NOTES - 1)) begin
                wrap = 1'b1;
            end else begin
                idx_n   = idx + AW'(1);
                state_n = FETCH;
            end
        end

        if (wrap) begin
            if (loop == LOOP_W'(REPEATS - 1)) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end else begin
                loop_n  = loop + LOOP_W'(1);
                idx_n   = '0;
                state_n = FETCH;
            end
        end

        // Idle keeps a clean, silent output and fresh counters for the next trigger.
        if (state_n == IDLE) begin
            period_n = '0;
            idx_n    = '0;
            loop_n   = '0;
            cnt_n    = '0;
            pre_n    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            idx         <= '0;
            loop        <= '0;
            cnt         <= '0;
            pre         <= '0;
            tone_period <= '0;
            tone_en     <= 1'b0;
            busy        <= 1'b0;
            alarm_done  <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            loop        <= loop_n;
            cnt         <= cnt_n;
            pre         <= pre_n;
            tone_period <= period_n;
            tone_en     <= (state_n == PLAY) && (period_n != '0);
            busy        <= (state_n != IDLE);
            alarm_done  <= done_n;
        end
    end

endmodule

// File: tb/tb_alarm_melody_sequencer.sv
// Scoreboard bench for alarm_melody_sequencer: expected output traces are queued
// when stimulus is applied and compared cycle by cycle on the falling edge.
module tb_alarm_melody_sequencer;

    localparam int TICK_DIV = 4;
    localparam int NOTES    = 4;
    localparam int GAP      = 1;
    localparam int REPEATS  = 2;
    localparam int SNZ      = 5;

    logic        clk = 1'b0;
    logic        rstn;
    logic        alarm_trig;
    logic        stop;
    logic        snooze;
    logic [1:0]  rom_addr;
    logic [19:0] rom_period;
    logic [9:0]  rom_dur;
    logic [19:0] tone_period;
    logic        tone_en;
    logic        busy;
    logic        alarm_done;

    logic [19:0] rom_p [NOTES];
    logic [9:0]  rom_d [NOTES];

    typedef struct {
        logic        en;
        logic [19:0] per;
        logic [1:0]  addr;
        bit          chk_addr;
        logic        busy;
        logic        done;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_no = 0;
    int   done_at = -1;
    int   t0;
    int   exp_len;

    alarm_melody_sequencer #(
        .TICK_DIV(TICK_DIV), .NOTES(NOTES), .PERIOD_W(20), .DUR_W(10),
        .GAP_TICKS(GAP), .REPEATS(REPEATS), .SNOOZE_TICKS(SNZ)
    ) dut (
        .clk(clk), .rstn(rstn), .alarm_trig(alarm_trig), .stop(stop), .snooze(snooze),
        .rom_addr(rom_addr), .rom_period(rom_period), .rom_dur(rom_dur),
        .tone_period(tone_period), .tone_en(tone_en), .busy(busy), .alarm_done(alarm_done)
    );

    always #5 clk = ~clk;

    // Synchronous note ROM: data follows the address by one cycle.
    always @(posedge clk) begin
        rom_period <= rom_p[rom_addr];
        rom_dur    <= rom_d[rom_addr];
    end

    task automatic push(input logic en, input logic [19:0] per, input logic [1:0] addr,
                        input bit chk_addr, input logic bsy, input logic dn, input string tag);
        exp_t e;
        e.en = en; e.per = per; e.addr = addr; e.chk_addr = chk_addr;
        e.busy = bsy; e.done = dn; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Expected trace of a melody run from its first FETCH through the done pulse.
    task automatic push_run(input int loops, input logic [19:0] start_per, input string tag);
        logic [19:0] cur;
        cur = start_per;
        for (int l = 0; l < loops; l++) begin
            for (int i = 0; i < NOTES; i++) begin
                push(1'b0, cur, 2'(i), 1'b1, 1'b1, 1'b0, tag);
                push(1'b0, cur, 2'(i), 1'b1, 1'b1, 1'b0, tag);
                if (rom_d[i] == 10'd0) break;
                cur = rom_p[i];
                for (int c = 0; c < int'(rom_d[i]) * TICK_DIV; c++)
                    push(cur != 20'd0, cur, 2'(i), 1'b1, 1'b1, 1'b0, tag);
                for (int c = 0; c < GAP * TICK_DIV; c++)
                    push(1'b0, cur, 2'(i), 1'b1, 1'b1, 1'b0, tag);
            end
        end
        push(1'b0, 20'd0, 2'd0, 1'b0, 1'b0, 1'b1, tag);
        push(1'b0, 20'd0, 2'd0, 1'b0, 1'b0, 1'b0, tag);
        push(1'b0, 20'd0, 2'd0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic check(input exp_t e);
        n_cmp++;
        assert (tone_en === e.en) else begin
            n_err++;
            $error("FAIL %s tone_en cyc %0d got %0b want %0b", e.tag, cyc_no, tone_en, e.en);
        end
        n_cmp++;
        assert (tone_period === e.per) else begin
            n_err++;
            $error("FAIL %s tone_period cyc %0d got %0d want %0d", e.tag, cyc_no, tone_period, e.per);
        end
        n_cmp++;
        assert (busy === e.busy) else begin
            n_err++;
            $error("FAIL %s busy cyc %0d got %0b want %0b", e.tag, cyc_no, busy, e.busy);
        end
        n_cmp++;
        assert (alarm_done === e.done) else begin
            n_err++;
            $error("FAIL %s alarm_done cyc %0d got %0b want %0b", e.tag, cyc_no, alarm_done, e.done);
        end
        if (e.chk_addr) begin
            n_cmp++;
            assert (rom_addr === e.addr) else begin
                n_err++;
                $error("FAIL %s rom_addr cyc %0d got %0d want %0d", e.tag, cyc_no, rom_addr, e.addr);
            end
        end
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        alarm_trig = 1'b0;
        stop       = 1'b0;
        snooze     = 1'b0;
        @(negedge clk);
        cyc_no++;
        if (alarm_done === 1'b1) done_at = cyc_no;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e);
        end
    endtask

    task automatic drain();
        while (exp_q.size() > 0) cyc();
    endtask

    initial begin
        rom_p = '{20'd100, 20'd0, 20'd250, 20'd80};
        rom_d = '{10'd3, 10'd2, 10'd1, 10'd2};
        rstn = 1'b0; alarm_trig = 1'b0; stop = 1'b0; snooze = 1'b0;

        // Reset held two cycles with a trigger that must be ignored, then long idle.
        for (int k = 0; k < 2; k++) begin
            alarm_trig = 1'b1;
            push(1'b0, 20'd0, 2'd0, 1'b1, 1'b0, 1'b0, "reset");
            cyc();
        end
        rstn = 1'b1;
        for (int k = 0; k < 200; k++) push(1'b0, 20'd0, 2'd0, 1'b1, 1'b0, 1'b0, "idle");
        drain();

        // Full run to auto-timeout, with a trigger during PLAY that must be ignored.
        exp_len = 1;
        for (int i = 0; i < NOTES; i++) exp_len += REPEATS * (2 + (int'(rom_d[i]) + GAP) * TICK_DIV);
        done_at = -1;
        t0 = cyc_no;
        alarm_trig = 1'b1;
        push_run(REPEATS, 20'd0, "melody");
        repeat (5) cyc();
        alarm_trig = 1'b1;
        drain();
        n_cmp++;
        assert (done_at - t0 === exp_len) else begin
            n_err++;
            $error("FAIL done_latency got %0d want %0d", done_at - t0, exp_len);
        end

        // End-of-melody marker at entry 2: loop wraps right after note 1.
        rom_d[2] = 10'd0;
        alarm_trig = 1'b1;
        push_run(REPEATS, 20'd0, "endmark");
        drain();
        rom_d[2] = 10'd1;

        // Snooze mid-note 0, then a second snooze inside SNOOZE restarting its count.
        alarm_trig = 1'b1;
        push_run(REPEATS, 20'd0, "pre_snooze");
        repeat (6) cyc();
        snooze = 1'b1;
        exp_q.delete();
        for (int k = 0; k < SNZ * TICK_DIV; k++) push(1'b0, 20'd100, 2'd0, 1'b0, 1'b1, 1'b0, "snooze1");
        repeat (7) cyc();
        snooze = 1'b1;
        exp_q.delete();
        for (int k = 0; k < SNZ * TICK_DIV; k++) push(1'b0, 20'd100, 2'd0, 1'b0, 1'b1, 1'b0, "snooze2");
        push_run(REPEATS, 20'd100, "resume");
        drain();

        // Stop and snooze in the same cycle: stop wins, no done pulse.
        alarm_trig = 1'b1;
        push_run(REPEATS, 20'd0, "pre_stop");
        repeat (4) cyc();
        stop = 1'b1;
        snooze = 1'b1;
        exp_q.delete();
        for (int k = 0; k < 6; k++) push(1'b0, 20'd0, 2'd0, 1'b0, 1'b0, 1'b0, "stop");
        drain();

        // Reset asserted mid-PLAY clears every output on the next cycle.
        alarm_trig = 1'b1;
        push_run(REPEATS, 20'd0, "pre_rst");
        repeat (5) cyc();
        rstn = 1'b0;
        exp_q.delete();
        push(1'b0, 20'd0, 2'd0, 1'b1, 1'b0, 1'b0, "rst_mid");
        cyc();
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) push(1'b0, 20'd0, 2'd0, 1'b1, 1'b0, 1'b0, "post_rst");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
